// File: rtl/seq_compare.sv
// Multi-cycle comparator: walks A and B CHUNK bits per cycle from the MSB chunk down,
// producing eq/lt/result for EQ, NE, signed and unsigned ordering ops.
module seq_compare #(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic             eq,
    output logic             lt
);

    // state  | meaning
    // S_IDLE | waiting for start
    // S_BUSY | one chunk compared per cycle, MSB chunk first
    // S_DONE | one-cycle done pulse; outputs freshly updated; start accepted here too

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N - 1);

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b010;
    localparam logic [2:0] OP_GE  = 3'b011;
    localparam logic [2:0] OP_LTU = 3'b100;
    localparam logic [2:0] OP_GEU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [2:0]         op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               decided_q;
    logic               lt_q;
    logic               result_q;
    logic               eq_q;
    logic               lt_out_q;

    logic [CHUNK-1:0]   chunk_a;
    logic [CHUNK-1:0]   chunk_b;
    logic               chunk_diff;
    logic               decide_now;
    logic               decided_nx;
    logic               lt_nx;
    logic               finish;
    logic               accept;
    logic               signed_op;
    logic               result_nx;

    function automatic logic outcome(input logic [2:0] o, input logic e, input logic l);
        logic r;
        r = 1'b0;
        case (o)
            OP_EQ:          r = e;
            OP_NE:          r = ~e;
            OP_LT, OP_LTU:  r = l;
            OP_GE, OP_GEU:  r = ~l;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

    // Operands are shifted left each cycle so the chunk under test is always the top one.
    always_comb begin
        chunk_a    = a_sh[WIDTH-1 -: CHUNK];
        chunk_b    = b_sh[WIDTH-1 -: CHUNK];
        chunk_diff = (chunk_a != chunk_b);
        decide_now = ~decided_q & chunk_diff;
        decided_nx = decided_q | chunk_diff;
        lt_nx      = decide_now ? (chunk_a < chunk_b) : lt_q;
        finish     = (cnt_q == '0) || ((EARLY_EXIT != 0) && decide_now);
        accept     = start && (state_q != S_BUSY);
        signed_op  = (op[2:1] == 2'b01);
        result_nx  = outcome(op_q, ~decided_nx, lt_nx);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_BUSY;
            S_BUSY:  if (finish) state_d = S_DONE;
            S_DONE:  state_d = accept ? S_BUSY : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            result_q  <= 1'b0;
            eq_q      <= 1'b0;
            lt_out_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                // Flipping the sign bit maps two's complement order onto unsigned order.
                a_sh      <= signed_op ? (a ^ MSB_MASK) : a;
                b_sh      <= signed_op ? (b ^ MSB_MASK) : b;
                op_q      <= op;
                cnt_q     <= CNT_INIT;
                decided_q <= 1'b0;
                lt_q      <= 1'b0;
            end else if (state_q == S_BUSY) begin
                a_sh      <= a_sh << CHUNK;
                b_sh      <= b_sh << CHUNK;
                cnt_q     <= cnt_q - 1'b1;
                decided_q <= decided_nx;
                lt_q      <= lt_nx;
                if (finish) begin
                    eq_q     <= ~decided_nx;
                    lt_out_q <= lt_nx;
                    result_q <= result_nx;
                end
            end
        end
    end

    assign busy   = (state_q == S_BUSY);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign eq     = eq_q;
    assign lt     = lt_out_q;

endmodule

// File: tb/tb_seq_compare.sv
// Bench for seq_compare: three instances (fixed latency, early exit, single pass) checked
// every cycle against a reference model, plus directed literal checks.
module tb_seq_compare;

    localparam int NI = 3;
    localparam logic [2:0] EQ = 3'b000, NE = 3'b001, LT = 3'b010, GE = 3'b011;
    localparam logic [2:0] LTU = 3'b100, GEU = 3'b101, RSV = 3'b110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  st  = '0;
    logic [31:0] a   = '0;
    logic [31:0] b   = '0;
    logic [2:0]  op  = '0;
    logic [2:0]  busy_w, done_w, res_w, eq_w, lt_w;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_compare #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .a(a), .b(b), .op(op),
        .busy(busy_w[0]), .done(done_w[0]), .result(res_w[0]), .eq(eq_w[0]), .lt(lt_w[0]));
    seq_compare #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .a(a), .b(b), .op(op),
        .busy(busy_w[1]), .done(done_w[1]), .result(res_w[1]), .eq(eq_w[1]), .lt(lt_w[1]));
    seq_compare #(.WIDTH(32), .CHUNK(32), .EARLY_EXIT(0)) dut2 (
        .clk(clk), .rst(rst), .start(st[2]), .a(a), .b(b), .op(op),
        .busy(busy_w[2]), .done(done_w[2]), .result(res_w[2]), .eq(eq_w[2]), .lt(lt_w[2]));

    int chunk_of [NI] = '{8, 8, 32};
    int early_of [NI] = '{0, 1, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Index (1 = MSB chunk) of the first differing chunk, 0 when the operands are equal.
    function automatic int first_diff(input logic [31:0] x, input logic [31:0] y, input int c);
        for (int j = 1; j <= 32 / c; j++)
            if (((x ^ y) >> (32 - j * c)) != 0) return j;
        return 0;
    endfunction

    function automatic logic ref_result(input logic [2:0] o, input logic e, input logic l);
        case (o)
            EQ: return e;
            NE: return ~e;
            LT, LTU: return l;
            GE, GEU: return ~l;
            default: return 1'b0;
        endcase
    endfunction

    // Reference model: remaining busy cycles and the pending outcome per instance.
    int   m_left [NI];
    logic m_done [NI];
    logic m_res [NI], m_eq [NI], m_lt [NI];
    logic p_res [NI], p_eq [NI], p_lt [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_left[i] = 0; m_done[i] = 0;
                m_res[i] = 0; m_eq[i] = 0; m_lt[i] = 0;
            end else begin
                automatic bit was_free = (m_left[i] == 0);
                m_done[i] = 0;
                if (m_left[i] > 0) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_done[i] = 1;
                        m_res[i] = p_res[i]; m_eq[i] = p_eq[i]; m_lt[i] = p_lt[i];
                    end
                end
                if (st[i] && was_free) begin
                    automatic int fd = first_diff(a, b, chunk_of[i]);
                    p_eq[i]  = (a == b);
                    p_lt[i]  = (op[2:1] == 2'b01) ? ($signed(a) < $signed(b)) : (a < b);
                    p_res[i] = ref_result(op, p_eq[i], p_lt[i]);
                    m_left[i] = (early_of[i] != 0 && fd != 0) ? fd : 32 / chunk_of[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("busy[%0d]", i), 32'(busy_w[i]), 32'(m_left[i] > 0));
                chk($sformatf("done[%0d]", i), 32'(done_w[i]), 32'(m_done[i]));
                chk($sformatf("result[%0d]", i), 32'(res_w[i]), 32'(m_res[i]));
                chk($sformatf("eq[%0d]", i), 32'(eq_w[i]), 32'(m_eq[i]));
                chk($sformatf("lt[%0d]", i), 32'(lt_w[i]), 32'(m_lt[i]));
            end
        end
    end

    task automatic go(input int i, input logic [31:0] xa, input logic [31:0] xb,
                      input logic [2:0] xo, input int exp_lat,
                      input logic e_res, input logic e_eq, input logic e_lt);
        int lat;
        @(negedge clk);
        a = xa; b = xb; op = xo; st[i] = 1'b1;
        @(negedge clk);
        st[i] = 1'b0;
        lat = 0;
        while (!done_w[i] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("latency[%0d] op=%0d", i, xo), lat, exp_lat);
        chk($sformatf("lit_result[%0d] %0h/%0h", i, xa, xb), 32'(res_w[i]), 32'(e_res));
        chk($sformatf("lit_eq[%0d] %0h/%0h", i, xa, xb), 32'(eq_w[i]), 32'(e_eq));
        chk($sformatf("lit_lt[%0d] %0h/%0h", i, xa, xb), 32'(lt_w[i]), 32'(e_lt));
    endtask

    initial begin
        int pos [$];
        int dcnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_busy", 32'(busy_w), 0);
        chk("reset_done", 32'(done_w), 0);
        chk("reset_result", 32'(res_w), 0);

        // Signed / unsigned ordering on the fixed-latency instance
        go(0, 32'd1, 32'd2, GE, 4, 0, 0, 1);
        go(0, -32'sd2, -32'sd1, GE, 4, 0, 0, 1);
        go(0, -32'sd1, -32'sd2, GE, 4, 1, 0, 0);
        go(0, 32'd0, 32'd0, EQ, 4, 1, 1, 0);
        go(0, -32'sd1, -32'sd1, NE, 4, 0, 1, 0);
        go(0, 32'd1, 32'd1, GE, 4, 1, 1, 0);
        go(0, -32'sd2, 32'd1, GEU, 4, 1, 0, 0);
        go(0, -32'sd2, 32'd1, GE, 4, 0, 0, 1);
        go(0, -32'sd1, 32'd2, LTU, 4, 0, 0, 0);
        go(0, 32'd3, 32'd5, RSV, 4, 0, 0, 1);

        // Start held high for 12 edges: accepts at k, k+5, k+10
        @(negedge clk);
        a = 32'd1; b = 32'd2; op = GE; st[0] = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (done_w[0]) pos.push_back(c);
            if (c == 11) st[0] = 1'b0;
        end
        chk("held_start_pulses", pos.size(), 3);
        if (pos.size() == 3) begin
            chk("held_start_first", pos[0], 4);
            chk("held_start_gap1", pos[1] - pos[0], 5);
            chk("held_start_gap2", pos[2] - pos[1], 5);
        end

        // Early exit
        go(1, 32'h8000_0000, 32'h0, LTU, 1, 0, 0, 0);
        go(1, 32'h1234_5678, 32'h1234_5678, EQ, 4, 1, 1, 0);
        go(1, 32'h0012_0000, 32'h0034_0000, LTU, 2, 1, 0, 1);

        // Reset mid-compare
        @(negedge clk);
        a = 32'd7; b = 32'd9; op = LTU; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy_w[0]), 0);
        chk("abort_done", 32'(done_w[0]), 0);
        rst = 1'b0;
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            dcnt += int'(done_w[0]);
        end
        chk("abort_no_done", dcnt, 0);
        go(0, 32'd7, 32'd9, LTU, 4, 1, 0, 1);

        // Single-pass instance
        go(2, 32'd5, 32'd3, LT, 1, 0, 0, 0);
        go(2, -32'sd5, 32'd3, LT, 1, 1, 0, 1);

        // Randomised traffic on all instances with occasional reset
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ (32'd1 << $urandom_range(0, 31));
                default: b = $urandom;
            endcase
            op  = 3'($urandom_range(0, 7));
            st  = 3'($urandom);
            rst = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        st = '0; rst = 1'b0;
        repeat (10) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
